// File: rtl/hazard_forward_unit.sv
// EXE/ID/MEM bypass selection plus load-use and long-op scoreboard stall generation.
// Also keeps a saturating stall-cycle counter and a sticky stall watchdog.
module hazard_forward_unit #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int NUM_REGS       = 32,
  parameter int REG_AW         = 5,
  parameter int TIMEOUT        = 256,
  parameter int SW             = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REG_AW-1:0]                rs1_id,
  input  logic [REG_AW-1:0]                rs2_id,
  input  logic                             rs1_use_id,
  input  logic                             rs2_use_id,
  input  logic [REG_AW-1:0]                rs1_exe,
  input  logic [REG_AW-1:0]                rs2_exe,
  input  logic [REG_AW-1:0]                rs2_mem,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]        stg_we,
  input  logic                             ex_is_load,
  input  logic [REG_AW-1:0]                ex_rd,
  input  logic                             lng_issue,
  input  logic [REG_AW-1:0]                lng_issue_rd,
  input  logic                             lng_done,
  input  logic [REG_AW-1:0]                lng_done_rd,
  output logic [SW-1:0]                    fwd_rs1_exe,
  output logic [SW-1:0]                    fwd_rs2_exe,
  output logic                             fwd_rs1_id,
  output logic                             fwd_rs2_id,
  output logic                             fwd_lng_rs1_id,
  output logic                             fwd_lng_rs2_id,
  output logic                             fwd_rs2_mem,
  output logic                             stall,
  output logic [NUM_REGS-1:0]              pending,
  output logic [31:0]                      stall_cycles,
  output logic                             hazard_timeout
);

  localparam int RW  = $clog2(TIMEOUT + 1);
  localparam int OLD = NUM_FWD_STAGES - 1;

  logic [NUM_FWD_STAGES-1:0] hit1_exe;
  logic [NUM_FWD_STAGES-1:0] hit2_exe;
  logic [REG_AW-1:0]         rd_old;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;
  logic [RW-1:0]       run_q, run_d;
  logic                timeout_q, timeout_d;

  logic load_use, sb_haz1, sb_haz2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD_STAGES; gi++) begin : g_hit
      logic [REG_AW-1:0] rd_k;
      assign rd_k         = stg_rd[gi*REG_AW +: REG_AW];
      assign hit1_exe[gi] = stg_we[gi] && (rd_k == rs1_exe) && (rs1_exe != '0);
      assign hit2_exe[gi] = stg_we[gi] && (rd_k == rs2_exe) && (rs2_exe != '0);
    end
  endgenerate

  assign rd_old = stg_rd[OLD*REG_AW +: REG_AW];

  // Scan oldest to youngest so the youngest hitting stage wins.
  always_comb begin
    fwd_rs1_exe = '0;
    fwd_rs2_exe = '0;
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (hit1_exe[k]) fwd_rs1_exe = SW'(k + 1);
      if (hit2_exe[k]) fwd_rs2_exe = SW'(k + 1);
    end
  end

  assign fwd_rs1_id  = stg_we[OLD] && (rd_old == rs1_id)  && (rs1_id != '0);
  assign fwd_rs2_id  = stg_we[OLD] && (rd_old == rs2_id)  && (rs2_id != '0);
  assign fwd_rs2_mem = stg_we[OLD] && (rd_old == rs2_mem) && (rs2_mem != '0);

  // A long op completing this cycle resolves its own scoreboard hazard via bypass.
  assign fwd_lng_rs1_id = rs1_use_id && (rs1_id != '0) && lng_done && (lng_done_rd == rs1_id);
  assign fwd_lng_rs2_id = rs2_use_id && (rs2_id != '0) && lng_done && (lng_done_rd == rs2_id);

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((rs1_use_id && (rs1_id == ex_rd)) || (rs2_use_id && (rs2_id == ex_rd)));
  assign sb_haz1  = rs1_use_id && pending_q[rs1_id] && !fwd_lng_rs1_id;
  assign sb_haz2  = rs2_use_id && pending_q[rs2_id] && !fwd_lng_rs2_id;
  assign stall    = load_use || sb_haz1 || sb_haz2;

  // Clear before set so a same-cycle issue and done on one register leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (lng_done && (lng_done_rd != '0)) pending_d[lng_done_rd] = 1'b0;
    if (lng_issue && (lng_issue_rd != '0)) pending_d[lng_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_comb begin
    run_d = '0;
    if (stall) run_d = (run_q == RW'(TIMEOUT)) ? run_q : run_q + RW'(1);
    timeout_d = timeout_q || (run_d == RW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= '0;
      stall_cycles_q <= '0;
      run_q          <= '0;
      timeout_q      <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      stall_cycles_q <= stall_cycles_d;
      run_q          <= run_d;
      timeout_q      <= timeout_d;
    end
  end

  assign pending        = pending_q;
  assign stall_cycles   = stall_cycles_q;
  assign hazard_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomised and directed bench for hazard_forward_unit (3 forwarding stages, TIMEOUT=4)
// checked against a rule-level model of forwarding, stalls, scoreboard and counters.
module tb_hazard_forward_unit;

  localparam int NS = 3;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_id, rs2_id, rs1_exe, rs2_exe, rs2_mem, ex_rd, lng_issue_rd, lng_done_rd;
  logic        rs1_use_id, rs2_use_id, ex_is_load, lng_issue, lng_done;
  logic [14:0] stg_rd;
  logic [2:0]  stg_we;
  logic [1:0]  fwd_rs1_exe, fwd_rs2_exe;
  logic        fwd_rs1_id, fwd_rs2_id, fwd_lng_rs1_id, fwd_lng_rs2_id, fwd_rs2_mem;
  logic        stall, hazard_timeout;
  logic [31:0] pending, stall_cycles;

  hazard_forward_unit #(.NUM_FWD_STAGES(NS), .NUM_REGS(32), .REG_AW(5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_use_id(rs1_use_id), .rs2_use_id(rs2_use_id),
    .rs1_exe(rs1_exe), .rs2_exe(rs2_exe), .rs2_mem(rs2_mem),
    .stg_rd(stg_rd), .stg_we(stg_we),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .lng_issue(lng_issue), .lng_issue_rd(lng_issue_rd),
    .lng_done(lng_done), .lng_done_rd(lng_done_rd),
    .fwd_rs1_exe(fwd_rs1_exe), .fwd_rs2_exe(fwd_rs2_exe),
    .fwd_rs1_id(fwd_rs1_id), .fwd_rs2_id(fwd_rs2_id),
    .fwd_lng_rs1_id(fwd_lng_rs1_id), .fwd_lng_rs2_id(fwd_lng_rs2_id),
    .fwd_rs2_mem(fwd_rs2_mem), .stall(stall), .pending(pending),
    .stall_cycles(stall_cycles), .hazard_timeout(hazard_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference state
  bit          m_pend [32];
  logic [31:0] m_cnt;
  int          m_run;
  bit          m_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit stage_hit(int k, logic [4:0] r);
    logic [4:0] rd;
    rd = stg_rd[k*5 +: 5];
    return (r != 0) && stg_we[k] && (rd == r);
  endfunction

  function automatic int exe_sel(logic [4:0] r);
    for (int k = 0; k < NS; k++) if (stage_hit(k, r)) return k + 1;
    return 0;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_cnt = 0;
    m_run = 0;
    m_to  = 0;
  endtask

  task automatic zero_inputs();
    rs1_id = 0; rs2_id = 0; rs1_use_id = 0; rs2_use_id = 0;
    rs1_exe = 0; rs2_exe = 0; rs2_mem = 0; stg_rd = 0; stg_we = 0;
    ex_is_load = 0; ex_rd = 0; lng_issue = 0; lng_issue_rd = 0;
    lng_done = 0; lng_done_rd = 0; reset = 0;
  endtask

  // Called just after a falling edge with inputs driven; checks, then advances one clock.
  task automatic cycle();
    bit lng1, lng2, lu, sb, e_stall;
    #1;
    lng1 = rs1_use_id && rs1_id != 0 && lng_done && lng_done_rd == rs1_id;
    lng2 = rs2_use_id && rs2_id != 0 && lng_done && lng_done_rd == rs2_id;
    lu   = ex_is_load && ex_rd != 0 &&
           ((rs1_use_id && rs1_id == ex_rd) || (rs2_use_id && rs2_id == ex_rd));
    sb   = (rs1_use_id && m_pend[rs1_id] && !lng1) || (rs2_use_id && m_pend[rs2_id] && !lng2);
    e_stall = lu || sb;
    chk("fwd_rs1_exe", 64'(fwd_rs1_exe), 64'(exe_sel(rs1_exe)));
    chk("fwd_rs2_exe", 64'(fwd_rs2_exe), 64'(exe_sel(rs2_exe)));
    chk("fwd_rs1_id", 64'(fwd_rs1_id), 64'(stage_hit(NS - 1, rs1_id)));
    chk("fwd_rs2_id", 64'(fwd_rs2_id), 64'(stage_hit(NS - 1, rs2_id)));
    chk("fwd_rs2_mem", 64'(fwd_rs2_mem), 64'(stage_hit(NS - 1, rs2_mem)));
    chk("fwd_lng_rs1", 64'(fwd_lng_rs1_id), 64'(lng1));
    chk("fwd_lng_rs2", 64'(fwd_lng_rs2_id), 64'(lng2));
    chk("stall", 64'(stall), 64'(e_stall));
    chk("pending", 64'(pending), 64'(pend_vec()));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    chk("hazard_timeout", 64'(hazard_timeout), 64'(m_to));
    $display("cyc %0d rst=%0b stall=%0b pend=%08h cnt=%0h to=%0b",
             cyc, reset, stall, pending, stall_cycles, hazard_timeout);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (lng_done && lng_done_rd != 0) m_pend[lng_done_rd] = 0;
      if (lng_issue && lng_issue_rd != 0) m_pend[lng_issue_rd] = 1;
      if (e_stall) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_run = (m_run + 1 > TO) ? TO : m_run + 1;
      end else begin
        m_run = 0;
      end
      if (m_run == TO) m_to = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit exceeded");
    $fatal(1, "time limit");
  end

  initial begin
    zero_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();

    // Youngest-stage EXE forwarding
    stg_we = 3'b111; stg_rd = {5'd5, 5'd5, 5'd5}; rs1_exe = 5;
    #1 chk("exe_sel_s0", 64'(fwd_rs1_exe), 64'd1);
    cycle();
    stg_we = 3'b110;
    #1 chk("exe_sel_s1", 64'(fwd_rs1_exe), 64'd2);
    cycle();
    stg_we = 3'b100;
    #1 chk("exe_sel_s2", 64'(fwd_rs1_exe), 64'd3);
    cycle();
    rs1_exe = 0; stg_we = 3'b111;
    #1 chk("exe_sel_x0", 64'(fwd_rs1_exe), 64'd0);
    cycle();
    zero_inputs();

    // Load-use for one cycle
    ex_is_load = 1; ex_rd = 7; rs2_id = 7; rs2_use_id = 1;
    #1 chk("lu_stall", 64'(stall), 64'd1);
    cycle();
    chk("lu_count", 64'(stall_cycles), 64'd1);
    rs2_use_id = 0;
    #1 chk("lu_unused", 64'(stall), 64'd0);
    cycle();
    zero_inputs();

    // Long-op scoreboard with completion bypass
    lng_issue = 1; lng_issue_rd = 9;
    cycle();
    zero_inputs();
    rs1_id = 9; rs1_use_id = 1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin lng_done = 1; lng_done_rd = 9; end
      #1;
      chk("sb_stall", 64'(stall), 64'(c != 4));
      chk("sb_fwd_lng", 64'(fwd_lng_rs1_id), 64'(c == 4));
      chk("sb_pend9", 64'(pending[9]), 64'd1);
      cycle();
    end
    zero_inputs();
    #1 chk("sb_pend9_clr", 64'(pending[9]), 64'd0);
    cycle();

    // Set wins over clear; x0 ignored
    lng_issue = 1; lng_issue_rd = 12;
    cycle();
    lng_done = 1; lng_done_rd = 12;
    cycle();
    chk("set_wins", 64'(pending[12]), 64'd1);
    zero_inputs();
    lng_issue = 1; lng_issue_rd = 0;
    cycle();
    chk("issue_x0", 64'(pending), 64'h1000);
    zero_inputs();

    // Watchdog: 5 consecutive scoreboard stalls
    rs1_id = 12; rs1_use_id = 1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("wd_before", 64'(hazard_timeout), 64'(c >= 4));
      cycle();
    end
    zero_inputs();
    cycle();
    chk("wd_sticky", 64'(hazard_timeout), 64'd1);
    reset = 1;
    cycle();
    reset = 0;
    #1;
    chk("rst_timeout", 64'(hazard_timeout), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_count", 64'(stall_cycles), 64'd0);
    cycle();

    // Saturation of the stall counter
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cycles_q;
    m_cnt = 32'hFFFF_FFFE;
    ex_is_load = 1; ex_rd = 3; rs1_id = 3; rs1_use_id = 1;
    repeat (3) cycle();
    chk("sat_count", 64'(stall_cycles), 64'hFFFF_FFFF);
    zero_inputs();
    cycle();

    // Randomised traffic on a small register window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      rs1_id       = 5'($urandom_range(0, 7));
      rs2_id       = 5'($urandom_range(0, 7));
      rs1_use_id   = 1'($urandom);
      rs2_use_id   = 1'($urandom);
      rs1_exe      = 5'($urandom_range(0, 7));
      rs2_exe      = 5'($urandom_range(0, 7));
      rs2_mem      = 5'($urandom_range(0, 7));
      stg_we       = 3'($urandom);
      stg_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_is_load   = ($urandom_range(0, 3) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      lng_issue    = ($urandom_range(0, 3) == 0);
      lng_issue_rd = 5'($urandom_range(0, 7));
      lng_done     = ($urandom_range(0, 2) == 0);
      lng_done_rd  = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
